// File: rtl/regfile_pkg.sv
// regfile_pkg: shared names for the context-switching register file.
//   Register map constants, context operation encodings and the
//   copy-engine state type used by regfile_ctx.
package regfile_pkg;

    localparam int REG_NULL = 0;
    localparam int REG_SF   = 16;
    localparam int REG_LR   = 17;
    localparam int REG_SP   = 18;

    localparam logic CTX_SAVE    = 1'b0;
    localparam logic CTX_RESTORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE,
        DONE
    } ctx_state_t;

    // True when a register address names a real, writable register.
    function automatic logic addr_ok(input logic [31:0] addr, input int num_regs);
        return (addr != 32'd0) && (addr < 32'(num_regs));
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port.
//   rd_addr_i   - register address to read
//   bank_i      - flattened live bank, register i at [i*DATA_W +: DATA_W]
//   wrN_acc_i   - write port N is enabled and will commit this cycle
//   wrN_addr_i  - write port N address
//   wrN_data_i  - write port N data
//   rd_data_o   - read result (0 for NULL or out-of-range addresses)
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int NUM_REGS   = 19,
    parameter int REG_ADDR_W = 5,
    parameter int BYPASS     = 1
) (
    input  logic [REG_ADDR_W-1:0]      rd_addr_i,
    input  logic [NUM_REGS*DATA_W-1:0] bank_i,
    input  logic                       wr0_acc_i,
    input  logic [REG_ADDR_W-1:0]      wr0_addr_i,
    input  logic [DATA_W-1:0]          wr0_data_i,
    input  logic                       wr1_acc_i,
    input  logic [REG_ADDR_W-1:0]      wr1_addr_i,
    input  logic [DATA_W-1:0]          wr1_data_i,
    output logic [DATA_W-1:0]          rd_data_o
);

    always_comb begin
        rd_data_o = '0;
        if (addr_ok(32'(rd_addr_i), NUM_REGS)) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rd_addr_i == REG_ADDR_W'(i)) begin
                    rd_data_o = bank_i[i*DATA_W +: DATA_W];
                end
            end
            // wr1 is applied last so it wins when both ports hit this address.
            if (BYPASS != 0) begin
                if (wr0_acc_i && (wr0_addr_i == rd_addr_i)) begin
                    rd_data_o = wr0_data_i;
                end
                if (wr1_acc_i && (wr1_addr_i == rd_addr_i)) begin
                    rd_data_o = wr1_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_ctx.sv
// regfile_ctx: register file with two write ports, NUM_RD read ports,
// optional write-to-read bypass and a shadow bank for context save/restore.
//   clk, rst           - clock, synchronous active-high reset
//   wr0_*, wr1_*       - write ports (wr1 wins on address collision)
//   rd_addr, rd_data   - packed read ports, port i at slice i
//   ctx_req, ctx_op    - start SAVE (0) or RESTORE (1), pulse in IDLE only
//   ctx_busy, ctx_done - copy in progress / one-cycle completion pulse
//   wr_stall           - writes are dropped while high (same as ctx_busy)
module regfile_ctx
    import regfile_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter int                NUM_REGS   = 19,
    parameter int                REG_ADDR_W = 5,
    parameter int                NUM_RD     = 3,
    parameter logic [DATA_W-1:0] SP_RESET   = {DATA_W{1'b1}},
    parameter int                BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr0_en,
    input  logic [REG_ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [REG_ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]            wr1_data,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    input  logic                         ctx_req,
    input  logic                         ctx_op,
    output logic                         ctx_busy,
    output logic                         ctx_done,
    output logic                         wr_stall
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    ctx_state_t              state_q, state_d;
    logic [REG_ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]       live_q   [NUM_REGS];
    logic [DATA_W-1:0]       shadow_q [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] live_flat;
    logic                    wr0_acc, wr1_acc;

    // Copy engine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= REG_ADDR_W'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ctx_busy = 1'b0;
        ctx_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctx_req) begin
                    state_d = (ctx_op == CTX_RESTORE) ? RESTORE : SAVE;
                    idx_d   = REG_ADDR_W'(1);
                end
            end
            SAVE, RESTORE: begin
                ctx_busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = REG_ADDR_W'(1);
                end else begin
                    idx_d = idx_q + REG_ADDR_W'(1);
                end
            end
            DONE: begin
                ctx_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_stall = ctx_busy;
    assign wr0_acc  = wr0_en && !ctx_busy && addr_ok(32'(wr0_addr), NUM_REGS);
    assign wr1_acc  = wr1_en && !ctx_busy && addr_ok(32'(wr1_addr), NUM_REGS);

    // Live and shadow banks; register 0 is never written after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                live_q[i]   <= (i == REG_SP) ? SP_RESET : '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if ((state_q == SAVE) && (idx_q == REG_ADDR_W'(i))) begin
                    shadow_q[i] <= live_q[i];
                end
                if ((state_q == RESTORE) && (idx_q == REG_ADDR_W'(i))) begin
                    live_q[i] <= shadow_q[i];
                end else if (wr1_acc && (wr1_addr == REG_ADDR_W'(i))) begin
                    live_q[i] <= wr1_data;
                end else if (wr0_acc && (wr0_addr == REG_ADDR_W'(i))) begin
                    live_q[i] <= wr0_data;
                end
            end
        end
    end

    always_comb begin
        live_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            live_flat[i*DATA_W +: DATA_W] = live_q[i];
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_port #(
            .DATA_W     (DATA_W),
            .NUM_REGS   (NUM_REGS),
            .REG_ADDR_W (REG_ADDR_W),
            .BYPASS     (BYPASS)
        ) u_rd_port (
            .rd_addr_i  (rd_addr[g*REG_ADDR_W +: REG_ADDR_W]),
            .bank_i     (live_flat),
            .wr0_acc_i  (wr0_acc),
            .wr0_addr_i (wr0_addr),
            .wr0_data_i (wr0_data),
            .wr1_acc_i  (wr1_acc),
            .wr1_addr_i (wr1_addr),
            .wr1_data_i (wr1_data),
            .rd_data_o  (rd_data[g*DATA_W +: DATA_W])
        );
    end

endmodule
